// File: rtl/gps_config_sequencer.sv
// Boot-time PMTK configurator: streams a fixed command ROM on the GPS UART TX byte stream,
// appending "*hh\r\n", then snoops the RX byte stream for the matching $PMTK001 ack.
module gps_config_sequencer #(
    parameter int SYSCLK_FREQ    = 100_000_000,
    parameter int BOOT_DELAY_MS  = 1000,
    parameter int ACK_TIMEOUT_MS = 1000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       sclk_i,
    input  logic       rstn_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       config_done_o,
    output logic       config_err_o,
    output logic [1:0] cmd_index_o
);

    localparam longint BOOT_CYC = longint'(BOOT_DELAY_MS) * longint'(SYSCLK_FREQ) / 1000;
    localparam longint ACK_CYC  = longint'(ACK_TIMEOUT_MS) * longint'(SYSCLK_FREQ) / 1000;
    localparam longint TMAX     = (BOOT_CYC > ACK_CYC) ? BOOT_CYC : ACK_CYC;
    localparam int     TW       = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int     AW       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam int LEN0 = 45;
    localparam int LEN1 = 12;
    localparam logic [LEN0*8-1:0] BODY0 =
        {"PMTK314,0,1,0,1,", "0,0,0,0,0,", "0,0,0,0,0,", "0,0,0,0,0"};
    localparam logic [LEN1*8-1:0] BODY1    = "PMTK220,1000";
    localparam logic [9*8-1:0]    ACK_HDR  = "$PMTK001,";
    localparam logic [3:0]        FLAG_POS = 4'd13;
    localparam logic [1:0]        LAST_CMD = 2'd1;

    typedef enum logic [3:0] {
        BOOT_WAIT, SEND_DOLLAR, SEND_BODY, SEND_STAR, SEND_CK_HI,
        SEND_CK_LO, SEND_CR, SEND_LF, WAIT_ACK, DONE, ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [5:0]      bidx_q, bidx_d;
    logic [7:0]      csum_q, csum_d;
    logic [3:0]      mpos_q, mpos_d;
    logic [AW-1:0]   att_q, att_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            ack_fail;
    logic [7:0]      cur_byte;

    function automatic logic [7:0] body_byte(input logic [1:0] cmd, input logic [5:0] idx);
        if (cmd == 2'd0) return BODY0[(LEN0 - 1 - int'(idx)) * 8 +: 8];
        return BODY1[(LEN1 - 1 - int'(idx)) * 8 +: 8];
    endfunction

    function automatic logic [5:0] body_last(input logic [1:0] cmd);
        return (cmd == 2'd0) ? 6'(LEN0 - 1) : 6'(LEN1 - 1);
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Ack ID digits are the three characters after "PMTK" in the command body.
    function automatic logic [7:0] ack_byte(input logic [1:0] cmd, input logic [3:0] pos);
        if (pos < 4'd9)  return ACK_HDR[(8 - int'(pos)) * 8 +: 8];
        if (pos < 4'd12) return body_byte(cmd, 6'(pos - 4'd5));
        return 8'h2C;
    endfunction

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bidx_d     = bidx_q;
        csum_d     = csum_q;
        mpos_d     = mpos_q;
        att_d      = att_q;
        cmd_d      = cmd_q;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        ack_fail   = 1'b0;
        cur_byte   = body_byte(cmd_q, bidx_q);
        case (state_q)
            BOOT_WAIT: begin
                if (timer_q == '0) state_d = SEND_DOLLAR;
                else               timer_d = timer_q - TW'(1);
            end
            SEND_DOLLAR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h24;
                csum_d     = '0;
                bidx_d     = '0;
                if (tx_ready_i) state_d = SEND_BODY;
            end
            SEND_BODY: begin
                tx_valid_o = 1'b1;
                tx_data_o  = cur_byte;
                if (tx_ready_i) begin
                    csum_d = csum_q ^ cur_byte;
                    if (bidx_q == body_last(cmd_q)) state_d = SEND_STAR;
                    else                            bidx_d  = bidx_q + 6'd1;
                end
            end
            SEND_STAR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h2A;
                if (tx_ready_i) state_d = SEND_CK_HI;
            end
            SEND_CK_HI: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hex_ascii(csum_q[7:4]);
                if (tx_ready_i) state_d = SEND_CK_LO;
            end
            SEND_CK_LO: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hex_ascii(csum_q[3:0]);
                if (tx_ready_i) state_d = SEND_CR;
            end
            SEND_CR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h0D;
                if (tx_ready_i) state_d = SEND_LF;
            end
            SEND_LF: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h0A;
                if (tx_ready_i) begin
                    state_d = WAIT_ACK;
                    timer_d = TW'(ACK_CYC - 1);
                    mpos_d  = '0;
                end
            end
            WAIT_ACK: begin
                // A flag byte on the expiry cycle is still judged as an ack.
                if (rx_valid_i && mpos_q == FLAG_POS) begin
                    mpos_d = '0;
                    if (rx_data_i == 8'h33) begin
                        att_d = '0;
                        if (cmd_q == LAST_CMD) begin
                            state_d = DONE;
                        end else begin
                            cmd_d   = cmd_q + 2'd1;
                            state_d = SEND_DOLLAR;
                        end
                    end else begin
                        ack_fail = 1'b1;
                    end
                end else begin
                    if (rx_valid_i) begin
                        if (rx_data_i == ack_byte(cmd_q, mpos_q)) mpos_d = mpos_q + 4'd1;
                        else if (rx_data_i == 8'h24)              mpos_d = 4'd1;
                        else                                      mpos_d = '0;
                    end
                    if (timer_q == '0) ack_fail = 1'b1;
                    else               timer_d  = timer_q - TW'(1);
                end
                if (ack_fail) begin
                    if (att_q < AW'(MAX_RETRIES)) begin
                        att_d   = att_q + AW'(1);
                        state_d = SEND_DOLLAR;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            DONE, ERROR: begin
                if (start_i) begin
                    cmd_d   = '0;
                    att_d   = '0;
                    state_d = SEND_DOLLAR;
                end
            end
            default: state_d = BOOT_WAIT;
        endcase
    end

    always_ff @(posedge sclk_i) begin
        if (!rstn_i) begin
            state_q <= BOOT_WAIT;
            timer_q <= TW'(BOOT_CYC - 1);
            bidx_q  <= '0;
            csum_q  <= '0;
            mpos_q  <= '0;
            att_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bidx_q  <= bidx_d;
            csum_q  <= csum_d;
            mpos_q  <= mpos_d;
            att_q   <= att_d;
            cmd_q   <= cmd_d;
        end
    end

    assign busy_o        = (state_q != DONE) && (state_q != ERROR);
    assign config_done_o = (state_q == DONE);
    assign config_err_o  = (state_q == ERROR);
    assign cmd_index_o   = cmd_q;

endmodule

// File: tb/tb_gps_config_sequencer.sv
// Bench for gps_config_sequencer: sentence-level byte model, per-cycle handshake/status checks,
// plus directed scenarios for boot delay, acks, retries, timeout boundary, start and reset.
module tb_gps_config_sequencer;

    localparam int SYSCLK_FREQ    = 10_000;
    localparam int BOOT_DELAY_MS  = 2;
    localparam int ACK_TIMEOUT_MS = 5;
    localparam int MAX_RETRIES    = 3;
    localparam int BOOT_CYC       = BOOT_DELAY_MS * SYSCLK_FREQ / 1000;
    localparam int ACK_CYC        = ACK_TIMEOUT_MS * SYSCLK_FREQ / 1000;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [1:0] cmd_index;
    logic       ready_slow = 1'b0;

    gps_config_sequencer #(
        .SYSCLK_FREQ(SYSCLK_FREQ), .BOOT_DELAY_MS(BOOT_DELAY_MS),
        .ACK_TIMEOUT_MS(ACK_TIMEOUT_MS), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .sclk_i(clk), .rstn_i(rstn), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .start_i(start), .busy_o(busy), .config_done_o(done), .config_err_o(err),
        .cmd_index_o(cmd_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- sentence model: expected accepted bytes with the command index they belong to
    typedef struct { logic [7:0] b; logic [1:0] c; } exp_t;
    exp_t exp_q[$];

    function automatic string body_of(input int c);
        string p;
        if (c != 0) return "PMTK220,1000";
        p = "PMTK314,0,1,0,1,";
        return {p, "0,0,0,0,0,", "0,0,0,0,0,", "0,0,0,0,0"};
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    function automatic void push_byte(input logic [7:0] b, input int c);
        exp_t e;
        e.b = b;
        e.c = c[1:0];
        exp_q.push_back(e);
    endfunction

    function automatic void push_sentence(input int c);
        string s;
        logic [7:0] cs;
        s  = body_of(c);
        cs = 8'h00;
        push_byte(8'h24, c);
        for (int i = 0; i < s.len(); i++) begin
            push_byte(s[i], c);
            cs = cs ^ s[i];
        end
        push_byte(8'h2A, c);
        push_byte(hexc(cs[7:4]), c);
        push_byte(hexc(cs[3:0]), c);
        push_byte(8'h0D, c);
        push_byte(8'h0A, c);
    endfunction

    // ---- per-cycle compare process
    int lf_count = 0, lf_cyc = 0, rise_count = 0, rise_cyc = 0, acc_count = 0;
    logic prev_valid = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00, h1 = 8'h00, h2 = 8'h00, h3 = 8'h00;
    logic [7:0] ck_hi = 8'h00, ck_lo = 8'h00;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rstn) begin
            check("busy_vs_flags", busy, !(done || err));
            check("flags_exclusive", done && err, 1'b0);
            if (!busy) check("idle_tx_valid", tx_valid, 1'b0);
            if (prev_stall) begin
                check("hold_valid", tx_valid, 1'b1);
                check("hold_data", tx_data, prev_data);
            end
            if (tx_valid && !prev_valid) begin
                rise_count++;
                rise_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                acc_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_byte: got %0h, expected no byte (cycle %0d)", tx_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", tx_data, mon_e.b);
                    check("cmd_index", cmd_index, mon_e.c);
                end
                if (tx_data == 8'h0A) begin
                    lf_count++;
                    lf_cyc = cyc;
                    ck_hi  = h3;
                    ck_lo  = h2;
                end
                h3 = h2;
                h2 = h1;
                h1 = tx_data;
            end
            prev_valid = tx_valid;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ready_slow ? ((cyc % 3) == 0) : 1'b1;
        end
    end

    // ---- stimulus helpers
    function automatic int cnt_of(input int w);
        case (w)
            0:       return lf_count;
            1:       return rise_count;
            default: return acc_count;
        endcase
    endfunction

    task automatic wait_evt(input int which, input int target, input string name);
        int k;
        k = 0;
        while (cnt_of(which) < target && k < 600) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (cnt_of(which) < target) begin
            tests++;
            fails++;
            $display("FAIL %s: event count %0d, expected %0d within %0d cycles", name, cnt_of(which), target, k);
        end
    endtask

    task automatic send_rx(input string s, input int at_cyc);
        @(posedge clk);
        #1;
        while (cyc < at_cyc) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < s.len(); i++) begin
            rx_valid = 1'b1;
            rx_data  = s[i];
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // ---- directed scenarios
    initial begin
        int rel;

        // 1: boot delay, first sentence exact
        push_sentence(0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        rel = cyc;
        wait_evt(1, rise_count + 1, "boot_rise");
        check("boot_delay", rise_cyc - rel, BOOT_CYC);
        wait_evt(0, lf_count + 1, "s1_lf");
        check("ck0_hi", ck_hi, "2");
        check("ck0_lo", ck_lo, "8");
        check("s1_drain", exp_q.size(), 0);

        // 2: acks for both commands -> DONE
        push_sentence(1);
        send_rx("$PMTK001,314,3\015\012", 0);
        wait_evt(0, lf_count + 1, "s2_lf");
        check("ck1_hi", ck_hi, "1");
        check("ck1_lo", ck_lo, "F");
        send_rx("$PMTK001,220,3\015\012", 0);
        settle(3);
        check("s2_done", done, 1'b1);
        check("s2_busy", busy, 1'b0);
        check("s2_err", err, 1'b0);
        check("s2_idx", cmd_index, 2'd1);
        check("s2_drain", exp_q.size(), 0);

        // 3: start from DONE with a 1-in-3 ready pattern
        ready_slow = 1'b1;
        push_sentence(0);
        pulse_start();
        @(negedge clk);
        #2;
        check("start_valid", tx_valid, 1'b1);
        check("start_dollar", tx_data, 8'h24);
        check("start_busy", busy, 1'b1);
        wait_evt(0, lf_count + 1, "s3_lf0");
        push_sentence(1);
        send_rx("$PMTK001,314,3", 0);
        wait_evt(0, lf_count + 1, "s3_lf1");
        send_rx("$PMTK001,220,3", 0);
        settle(3);
        check("s3_done", done, 1'b1);
        check("s3_idx", cmd_index, 2'd1);
        check("s3_drain", exp_q.size(), 0);
        ready_slow = 1'b0;
        settle(2);

        // 4: no ack -> four attempts 50 idle cycles apart, then ERROR
        for (int a = 0; a <= MAX_RETRIES; a++) push_sentence(0);
        pulse_start();
        for (int a = 0; a <= MAX_RETRIES; a++) begin
            wait_evt(0, lf_count + 1, "s4_lf");
            if (a == 0) pulse_start();
            if (a < MAX_RETRIES) begin
                wait_evt(1, rise_count + 1, "s4_retry");
                check("retry_gap", rise_cyc - lf_cyc - 1, ACK_CYC);
            end
        end
        settle(ACK_CYC + 5);
        check("s4_err", err, 1'b1);
        check("s4_done", done, 1'b0);
        check("s4_busy", busy, 1'b0);
        check("s4_idx", cmd_index, 2'd0);
        check("s4_drain", exp_q.size(), 0);

        // 5: nack, wrong-ID ack, ack on the expiry cycle, '$' restart inside an ack
        push_sentence(0);
        pulse_start();
        wait_evt(0, lf_count + 1, "s5_lf0");
        push_sentence(0);
        send_rx("$PMTK001,314,2\015\012", 0);
        wait_evt(0, lf_count + 1, "s5_lf1");
        push_sentence(0);
        send_rx("$PMTK001,220,3\015\012", 0);
        wait_evt(1, rise_count + 1, "s5_timeout");
        check("wrong_id_gap", rise_cyc - lf_cyc - 1, ACK_CYC);
        wait_evt(0, lf_count + 1, "s5_lf2");
        push_sentence(1);
        send_rx("$PMTK001,314,3", lf_cyc + ACK_CYC - 13);
        wait_evt(0, lf_count + 1, "s5_lf3");
        send_rx("$PM$PMTK001,220,3", 0);
        settle(3);
        check("s5_done", done, 1'b1);
        check("s5_idx", cmd_index, 2'd1);
        check("s5_drain", exp_q.size(), 0);

        // 6: one-cycle reset mid-body restarts the boot delay and the sentence
        push_sentence(0);
        pulse_start();
        wait_evt(2, acc_count + 10, "s6_body");
        @(posedge clk);
        #1 rstn = 1'b0;
        exp_q.delete();
        push_sentence(0);
        @(posedge clk);
        #1 rstn = 1'b1;
        rel = cyc;
        @(negedge clk);
        #2;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b1);
        check("rst_idx", cmd_index, 2'd0);
        wait_evt(1, rise_count + 1, "s6_rise");
        check("reboot_delay", rise_cyc - rel, BOOT_CYC);
        wait_evt(0, lf_count + 1, "s6_lf");
        check("s6_drain", exp_q.size(), 0);
        check("s6_busy", busy, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected summary first", cyc);
        $fatal(1, "watchdog");
    end

endmodule
